// File: rtl/ofm_writeback.sv
// OFM writeback stage: captures 16 x 8-bit PE results as one 128-bit group,
// queues groups in a small FIFO and serializes each into four 32-bit BRAM
// writes at linear NHWC word addresses.
module ofm_writeback #(
  parameter int OFM_W      = 56,
  parameter int OFM_H      = 56,
  parameter int OFM_C      = 32,
  parameter int PE_NUM     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       valid,
  input  logic [127:0]      ofm_data,
  output logic              ofm_stall,
  output logic              ofm_we,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic [31:0]       ofm_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_partial,
  output logic              err_overflow
);

  localparam int T      = OFM_C / PE_NUM;
  localparam int NPIX   = OFM_W * OFM_H;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int TILE_W = (T > 1) ? $clog2(T) : 1;
  localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [127:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [1:0]          word_reg;
  logic [TILE_W-1:0]   tile_reg;
  logic [PIX_W-1:0]    pix_reg;
  logic [ADDR_W-1:0]   pix_off_reg;   // pix * (OFM_C/4), kept incrementally
  logic [ADDR_W-1:0]   tile_off_reg;  // tile * 4, kept incrementally
  logic                last_reg;      // final group of the frame has been written
  logic                ofm_we_reg;
  logic [ADDR_W-1:0]   ofm_addr_reg;
  logic [31:0]         ofm_wdata_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_partial_reg;
  logic                err_overflow_reg;

  logic         full;
  logic         in_run;
  logic         grp_ok;
  logic         grp_bad;
  logic         ser;
  logic         pop;
  logic         push;
  logic         overflow;
  logic         last_grp;
  logic [127:0] head;
  logic [31:0]  head_word [4];

  assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
  assign in_run   = (state_reg == RUN);
  assign grp_ok   = in_run && (valid == 16'hFFFF);
  assign grp_bad  = in_run && (valid != 16'h0000) && (valid != 16'hFFFF);
  // Serialize only while a group is queued and the frame still has groups to place.
  assign ser      = in_run && !last_reg && (count_reg != '0);
  assign pop      = ser && (word_reg == 2'd3);
  assign push     = grp_ok && (!full || pop);
  assign overflow = grp_ok && full && !pop;
  assign last_grp = (pix_reg == PIX_W'(NPIX - 1)) && (tile_reg == TILE_W'(T - 1));
  assign head     = mem[rd_ptr_reg];

  // Word w of the head group carries channels 4w..4w+3, lowest channel in the low byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign head_word[gi] = head[32*gi +: 32];
    end
  endgenerate

  // Group storage; written only when a push is accepted, read asynchronously at the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= ofm_data;
    end
  end

  // Control FSM, FIFO bookkeeping, address counters and registered BRAM outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      base_reg         <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      word_reg         <= '0;
      tile_reg         <= '0;
      pix_reg          <= '0;
      pix_off_reg      <= '0;
      tile_off_reg     <= '0;
      last_reg         <= 1'b0;
      ofm_we_reg       <= 1'b0;
      ofm_addr_reg     <= '0;
      ofm_wdata_reg    <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_partial_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      ofm_we_reg <= 1'b0;
      done_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg        <= RUN;
            busy_reg         <= 1'b1;
            base_reg         <= base_addr;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            word_reg         <= '0;
            tile_reg         <= '0;
            pix_reg          <= '0;
            pix_off_reg      <= '0;
            tile_off_reg     <= '0;
            last_reg         <= 1'b0;
            err_partial_reg  <= 1'b0;
            err_overflow_reg <= 1'b0;
          end
        end
        RUN: begin
          // Leave RUN the cycle after the final word is on the bus.
          if (last_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      if (grp_bad) begin
        err_partial_reg <= 1'b1;
      end
      if (overflow) begin
        err_overflow_reg <= 1'b1;
      end

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (state_reg != IDLE) begin
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end

      if (ser) begin
        ofm_we_reg    <= 1'b1;
        ofm_addr_reg  <= base_reg + pix_off_reg + tile_off_reg + ADDR_W'(word_reg);
        ofm_wdata_reg <= head_word[word_reg];
        word_reg      <= word_reg + 2'd1;
        if (word_reg == 2'd3) begin
          if (last_grp) begin
            last_reg <= 1'b1;
          end else if (tile_reg == TILE_W'(T - 1)) begin
            tile_reg     <= '0;
            tile_off_reg <= '0;
            pix_reg      <= pix_reg + PIX_W'(1);
            pix_off_reg  <= pix_off_reg + ADDR_W'(OFM_C / 4);
          end else begin
            tile_reg     <= tile_reg + TILE_W'(1);
            tile_off_reg <= tile_off_reg + ADDR_W'(4);
          end
        end
      end
    end
  end

  assign ofm_stall    = full;
  assign ofm_we       = ofm_we_reg;
  assign ofm_addr     = ofm_addr_reg;
  assign ofm_wdata    = ofm_wdata_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err_partial  = err_partial_reg;
  assign err_overflow = err_overflow_reg;

endmodule

// File: tb/tb_ofm_writeback.sv
// Scoreboard bench for ofm_writeback: stimulus queues the expected BRAM writes
// (address, data, cycle); a negedge monitor pops and compares every ofm_we beat.
module tb_ofm_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  valid;
  logic [127:0] ofm_data;
  logic         ofm_stall;
  logic         ofm_we;
  logic [31:0]  ofm_addr;
  logic [31:0]  ofm_wdata;
  logic         busy;
  logic         done;
  logic         err_partial;
  logic         err_overflow;

  always #5 clk = ~clk;

  ofm_writeback #(
    .OFM_W(2), .OFM_H(1), .OFM_C(32), .PE_NUM(16), .FIFO_DEPTH(4), .ADDR_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .valid(valid), .ofm_data(ofm_data), .ofm_stall(ofm_stall),
    .ofm_we(ofm_we), .ofm_addr(ofm_addr), .ofm_wdata(ofm_wdata),
    .busy(busy), .done(done), .err_partial(err_partial), .err_overflow(err_overflow)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sched_next = 0;
  int   exp_done_cyc = -1;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] mkgrp(input logic [7:0] seed);
    logic [127:0] g;
    for (int i = 0; i < 16; i++) g[8*i +: 8] = seed + 8'(i);
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one full group for one cycle; if accept, queue its four expected writes.
  task automatic push_group(input logic [7:0] seed, input logic [31:0] addr,
                            input bit accept, input bit last);
    logic [127:0] g;
    exp_t e;
    int n, st;
    g = mkgrp(seed);
    valid = 16'hFFFF;
    ofm_data = g;
    if (accept) begin
      n  = cyc + 1;
      st = (n + 1 > sched_next) ? n + 1 : sched_next;
      for (int w = 0; w < 4; w++) begin
        e.addr = addr + 32'(w);
        e.data = g[32*w +: 32];
        e.cyc  = st + w;
        sbq.push_back(e);
      end
      sched_next = st + 4;
      if (last) exp_done_cyc = st + 4;
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d writes outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: every write beat is matched against the head of the scoreboard.
  exp_t m_e;
  always @(negedge clk) begin
    if (ofm_we === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h cyc %0d, required no write",
                 ofm_addr, ofm_wdata, cyc);
      end else begin
        m_e = sbq.pop_front();
        if (ofm_addr !== m_e.addr || ofm_wdata !== m_e.data || cyc != m_e.cyc) begin
          errors++;
          $display("FAIL write: addr 0x%08h data 0x%08h cyc %0d, required addr 0x%08h data 0x%08h cyc %0d",
                   ofm_addr, ofm_wdata, cyc, m_e.addr, m_e.data, m_e.cyc);
        end else begin
          $display("write addr 0x%08h data 0x%08h cyc %0d ok", ofm_addr, ofm_wdata, cyc);
        end
      end
    end
    if (done === 1'b1 || cyc == exp_done_cyc) begin
      checks++;
      if (done !== (cyc == exp_done_cyc) || (done === 1'b1 && busy !== 1'b0)) begin
        errors++;
        $display("FAIL done_pulse: done %0b busy %0b at cyc %0d, required done only at cyc %0d with busy 0",
                 done, busy, cyc, exp_done_cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; valid = '0; ofm_data = '0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(ofm_we), 32'd0);
    check("rst_addr", ofm_addr, 32'd0);
    check("rst_wdata", ofm_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(ofm_stall), 32'd0);
    check("rst_err_partial", 32'(err_partial), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Frame A, base 0x100: single group OFM_i = i -> 0x03020100, 0x07060504, ...
    start = 1'b1; base_addr = 32'h100;
    @(negedge clk);
    start = 1'b0; base_addr = '0;
    check("a_busy", 32'(busy), 32'd1);
    push_group(8'h00, 32'h100, 1'b1, 1'b0);
    valid = '0;
    wait_drain("a_g0");

    // Partial valid: error flag only, nothing captured or written.
    valid = 16'h00FF; ofm_data = mkgrp(8'hA0);
    @(negedge clk);
    valid = '0;
    check("a_err_partial_set", 32'(err_partial), 32'd1);
    repeat (6) @(negedge clk);
    check("a_err_partial_hold", 32'(err_partial), 32'd1);

    // Two back-to-back groups (tile 1 of pixel 0, tile 0 of pixel 1), then the last.
    push_group(8'h20, 32'h104, 1'b1, 1'b0);
    push_group(8'h40, 32'h108, 1'b1, 1'b0);
    valid = '0;
    push_group(8'h60, 32'h10C, 1'b1, 1'b1);
    valid = '0;
    wait_drain("a_rest");
    repeat (3) @(negedge clk);
    check("a_busy_end", 32'(busy), 32'd0);
    check("a_err_partial_end", 32'(err_partial), 32'd1);
    check("a_err_overflow_end", 32'(err_overflow), 32'd0);

    // Frame B, base 0: six groups in consecutive cycles; the sixth overflows.
    start = 1'b1; base_addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check("b_err_partial_cleared", 32'(err_partial), 32'd0);
    for (int k = 0; k < 6; k++) begin
      push_group(8'(k * 16 + 1), 32'(k * 4), (k < 4), (k == 3));
      check($sformatf("b_stall_%0d", k), 32'(ofm_stall), 32'(k >= 3));
      check($sformatf("b_err_overflow_%0d", k), 32'(err_overflow), 32'(k == 5));
    end
    valid = '0;
    wait_drain("b");
    repeat (3) @(negedge clk);
    check("b_busy_end", 32'(busy), 32'd0);
    check("b_err_overflow_end", 32'(err_overflow), 32'd1);

    // A group offered in IDLE after the frame is ignored.
    push_group(8'hF0, 32'h0, 1'b0, 1'b0);
    valid = '0;
    repeat (8) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Reset mid-frame: word 0 goes out, then everything aborts.
    start = 1'b1; base_addr = 32'h200;
    @(negedge clk);
    start = 1'b0;
    push_group(8'h33, 32'h200, 1'b1, 1'b0);
    valid = '0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    exp_done_cyc = -1;
    repeat (2) @(negedge clk);
    check("mid_rst_we", 32'(ofm_we), 32'd0);
    check("mid_rst_addr", ofm_addr, 32'd0);
    check("mid_rst_wdata", ofm_wdata, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err_partial", 32'(err_partial), 32'd0);
    check("mid_rst_err_overflow", 32'(err_overflow), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_we", 32'(ofm_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
